iram_responder: RTL and testbench
=================================

// Module: iram_responder
// PURPOSE
//  Responder end of the core's memory request bus (req/addr_ok/data_ok), used by IF and data accesses.
//  Owns a word-addressed internal RAM, serves one request per cycle in order, and returns each
//  response after a fixed LATENCY. Used as on-chip instruction/data RAM and as the sim memory model.
//  Optional pseudo-random addr_ok stalls exercise initiator backpressure paths.
// PARAMETERS
//  DEPTH      1024       number of XLEN-bit words; power of 2
//  LATENCY    1          cycles from accept edge to data_ok; >=1 (IF requires 1)
//  STALL_EN   0          1: LFSR gates addr_ok low ~25% of cycles
//  INIT_FILE  ""         $readmemh image loaded at time 0 when non-empty
// PORTS
//  clk        in   1          clock
//  rst_b      in   1          async active-low reset
//  req        in   1          request valid
//  write      in   1          1=write, 0=read
//  wstrb      in   XLEN/8     byte write enables (write only)
//  addr       in   XLEN       byte address; [1:0] ignored
//  wdata      in   XLEN       write data
//  addr_ok    out  1          request accepted this cycle when req&addr_ok
//  data_ok    out  1          one-cycle response pulse, one per accepted request, in order
//  rdata      out  XLEN       read data, valid when data_ok
// BEHAVIOUR
//  - Clock and reset: one clock; reset is asynchronous and active-low (rst_b).
//  - Reset values: data_ok=0, rdata=0, response pipe valids=0, LFSR=16'hACE1; addr_ok=0 while rst_b=0.
//  - RAM contents are not reset; a reset mid-operation drops all in-flight responses, RAM keeps state.
//  - addr_ok = rst_b & ~stall; stall = STALL_EN & lfsr[0] & lfsr[1]; never depends on req.
//  - LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every cycle regardless of req.
//  - Index = addr[$clog2(DEPTH)+1:2]; higher address bits ignored (aliasing wraps).
//  - Accept (req&addr_ok) at edge N:
//    - write: bytes with wstrb[i]=1 updated at edge N;
//    - read: word latched at edge N from pre-edge contents.
//  - Ordering: a read accepted after a write to the same word returns the new data.
//    The write lands at an earlier edge, so no bypass logic is needed.
//  - Response pipe, LATENCY stages of {valid, rdata}: stage0 loads at the accept edge.
//    data_ok is high in cycle N+LATENCY (LATENCY=1: the cycle after acceptance).
//  - Writes also produce data_ok with rdata=0; reads return the word.
//  - No backpressure on responses: the initiator must sink data_ok every cycle; at most LATENCY in flight.
//  - Back-to-back accepts every cycle give a data_ok every cycle; throughput is 1/cycle.
//  - req low or stalled: stage0 valid=0; rdata holds 0 when data_ok=0.
//  - write=1 with wstrb=0: no RAM change, still responds.
// STRUCTURE
//  - XLEN and PC_RESET_ADDR come from config.svh.
//  - LFSR seed/taps and the stall threshold are localparams; no new package types.
//  - Sub-module resp_delay_pipe #(WIDTH=XLEN+1, STAGES=LATENCY): async-reset shift register for {valid, rdata}.
//  - RAM array, byte-strobe write and LFSR stay in this module.
// TESTING
//  1. Reset release, read 0x0000_0000 (INIT word0=0x0000_0013) -> addr_ok=1 same cycle; data_ok next cycle, rdata=0x13.
//  2. Write 0x100 wdata=0xDEADBEEF wstrb=4'b0101, then read 0x100 (prior 0) -> responses in order; second rdata=0x00AD00EF.
//  3. 8 back-to-back reads 0x0,0x4..0x1C, LATENCY=3 -> 8 consecutive data_ok pulses from the 4th cycle, in address order.
//  4. STALL_EN=1, req held 200 cycles -> accepts == data_ok count; addr_ok low ~50 cycles and matches the reference LFSR model.
//  5. rst_b asserted with 2 reads in flight (LATENCY=3) -> data_ok low at once and after release; earlier-written RAM data intact.
//  6. DEPTH=1024: read 0x1000 -> returns word at 0x0 (wrap); read 0x103 -> word at 0x100.

Source files
------------

// File: rtl/iram_responder_pkg.sv
// Shared constants and helpers for the internal RAM responder.
//   XLEN          - data path width of the core memory bus
//   PC_RESET_ADDR - fetch address after reset; word 0 of the RAM image normally sits here
//   lfsr16_step   - one shift of a right-shifting Fibonacci LFSR with an arbitrary tap mask
package iram_responder_pkg;

    localparam int unsigned     XLEN          = 32;
    localparam logic [XLEN-1:0] PC_RESET_ADDR = 32'h0000_0000;

    // Feedback is the XOR of all tapped bits and enters at the MSB.
    function automatic logic [15:0] lfsr16_step(input logic [15:0] state,
                                                input logic [15:0] taps);
        return {^(state & taps), state[15:1]};
    endfunction

endpackage

// File: rtl/iram_responder_resp_delay_pipe.sv
// Fixed-latency response pipe for the RAM responder.
// Each stage holds {valid, rdata}. din is captured into stage 0 every cycle and shifts one
// stage per cycle; dout is the last stage, so a word appears STAGES cycles after capture.
// Ports:
//   clk    - clock
//   rst_b  - asynchronous active-low reset; clears every stage (drops in-flight responses)
//   din    - {valid, rdata} presented at the accept edge
//   dout   - {valid, rdata} from the oldest stage
module resp_delay_pipe #(
    parameter int unsigned WIDTH  = 33,
    parameter int unsigned STAGES = 1
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int s = 0; s < STAGES; s++) begin
                stage_q[s] <= '0;
            end
        end else begin
            stage_q[0] <= din;
            for (int s = 1; s < STAGES; s++) begin
                stage_q[s] <= stage_q[s-1];
            end
        end
    end

    assign dout = stage_q[STAGES-1];

endmodule

// File: rtl/iram_responder.sv
// Responder end of the core memory request bus (req/addr_ok/data_ok).
// Owns a word-addressed RAM, accepts at most one request per cycle, and returns every accepted
// request (read or write) as a one-cycle data_ok pulse exactly LATENCY cycles later, in order.
// An optional LFSR drops addr_ok on roughly a quarter of cycles to exercise initiator stalls.
// Ports:
//   clk      - clock
//   rst_b    - asynchronous active-low reset (RAM contents are kept)
//   req      - request valid
//   write    - 1 = write, 0 = read
//   wstrb    - byte enables for writes
//   addr     - byte address; [1:0] and bits above the RAM index are ignored
//   wdata    - write data
//   addr_ok  - request accepted this cycle when req & addr_ok
//   data_ok  - response pulse
//   rdata    - read data while data_ok, otherwise 0 (also 0 for write responses)
module iram_responder
    import iram_responder_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 1,
    parameter bit          STALL_EN  = 1'b0,
    parameter string       INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              req,
    input  logic              write,
    input  logic [XLEN/8-1:0] wstrb,
    input  logic [XLEN-1:0]   addr,
    input  logic [XLEN-1:0]   wdata,
    output logic              addr_ok,
    output logic              data_ok,
    output logic [XLEN-1:0]   rdata
);

    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned NBYTES = XLEN / 8;

    // x^16 + x^14 + x^13 + x^11 in right-shift form taps state bits 0, 2, 3 and 5.
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS  = 16'h002D;
    // Stall when both low bits are set: one cycle in four on average.
    localparam logic [1:0]  STALL_MASK = 2'b11;

    logic [XLEN-1:0]  mem [DEPTH];
    logic [15:0]      lfsr_q;
    logic             stall;
    logic             accept;
    logic [IDX_W-1:0] idx;
    logic [XLEN:0]    pipe_in;
    logic [XLEN:0]    pipe_out;
    logic             unused_addr;

    assign idx         = addr[IDX_W+1:2];
    assign unused_addr = ^{addr[XLEN-1:IDX_W+2], addr[1:0]};

    // Free-running: the stall pattern depends only on cycles since reset, never on traffic.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr16_step(lfsr_q, LFSR_TAPS);
        end
    end

    assign stall   = STALL_EN && ((lfsr_q[1:0] & STALL_MASK) == STALL_MASK);
    assign addr_ok = rst_b & ~stall;
    assign accept  = req & addr_ok;

    // A write lands at its accept edge, so any later read already sees it without a bypass.
    always_ff @(posedge clk) begin
        if (accept && write) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (wstrb[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Data field is forced to 0 unless this is an accepted read, which keeps rdata at 0
    // whenever data_ok is low and for write responses.
    always_comb begin
        pipe_in = '0;
        if (accept) begin
            pipe_in[XLEN] = 1'b1;
            if (!write) begin
                pipe_in[XLEN-1:0] = mem[idx];
            end
        end
    end

    resp_delay_pipe #(
        .WIDTH  (XLEN + 1),
        .STAGES (LATENCY)
    ) u_resp_pipe (
        .clk   (clk),
        .rst_b (rst_b),
        .din   (pipe_in),
        .dout  (pipe_out)
    );

    assign data_ok = pipe_out[XLEN];
    assign rdata   = pipe_out[XLEN-1:0];

endmodule

// File: tb/tb_iram_responder.sv
module tb_iram_responder;
    import iram_responder_pkg::*;

    logic clk   = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    // Instance a: LATENCY=1, no stalls
    logic        req_a, wr_a, aok_a, dok_a;
    logic [3:0]  strb_a;
    logic [31:0] addr_a, wd_a, rd_a;
    // Instance b: LATENCY=3, no stalls
    logic        req_b, wr_b, aok_b, dok_b;
    logic [3:0]  strb_b;
    logic [31:0] addr_b, wd_b, rd_b;
    // Instance c: LATENCY=1, stalls enabled
    logic        req_c, wr_c, aok_c, dok_c;
    logic [3:0]  strb_c;
    logic [31:0] addr_c, wd_c, rd_c;

    iram_responder #(.DEPTH(1024), .LATENCY(1), .STALL_EN(1'b0), .INIT_FILE("")) u_dut_a (
        .clk(clk), .rst_b(rst_b), .req(req_a), .write(wr_a), .wstrb(strb_a), .addr(addr_a),
        .wdata(wd_a), .addr_ok(aok_a), .data_ok(dok_a), .rdata(rd_a)
    );
    iram_responder #(.DEPTH(1024), .LATENCY(3), .STALL_EN(1'b0), .INIT_FILE("")) u_dut_b (
        .clk(clk), .rst_b(rst_b), .req(req_b), .write(wr_b), .wstrb(strb_b), .addr(addr_b),
        .wdata(wd_b), .addr_ok(aok_b), .data_ok(dok_b), .rdata(rd_b)
    );
    iram_responder #(.DEPTH(1024), .LATENCY(1), .STALL_EN(1'b1), .INIT_FILE("")) u_dut_c (
        .clk(clk), .rst_b(rst_b), .req(req_c), .write(wr_c), .wstrb(strb_c), .addr(addr_c),
        .wdata(wd_c), .addr_ok(aok_c), .data_ok(dok_c), .rdata(rd_c)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference stall generator: taps 16,14,13,11, seed ACE1, shifting right.
    logic [15:0] m_lfsr;
    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end

    // One request on instance a, starting and ending at a negedge.
    task automatic xact_a(input string tag, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] st, input logic [31:0] exp);
        req_a = 1'b1; wr_a = wr; addr_a = a; wd_a = wd; strb_a = st;
        check_eq({tag, "_aok"}, {31'b0, aok_a}, 32'd1);
        @(negedge clk);
        req_a = 1'b0;
        check_eq({tag, "_dok"}, {31'b0, dok_a}, 32'd1);
        check_eq({tag, "_rdata"}, rd_a, exp);
    endtask

    // Eight back-to-back requests to words 0..7 on instance b, watching the response train.
    task automatic burst_b(input string tag, input logic wr);
        for (int c = 0; c < 12; c++) begin
            logic exp_v;
            exp_v = (c >= 3) && (c < 11);
            check_eq($sformatf("%s_dok%0d", tag, c), {31'b0, dok_b}, {31'b0, exp_v});
            check_eq($sformatf("%s_rd%0d", tag, c), rd_b,
                     (exp_v && !wr) ? 32'h1000_0000 + 32'(c - 3) : 32'h0);
            req_b  = (c < 8);
            wr_b   = wr;
            addr_b = 32'(4 * c);
            wd_b   = 32'h1000_0000 + 32'(c);
            strb_b = 4'hF;
            @(negedge clk);
        end
        req_b = 1'b0;
    endtask

    initial begin
        int acc, dok, stalls, mism, rd_bad;
        req_a = 0; wr_a = 0; strb_a = 0; addr_a = 0; wd_a = 0;
        req_b = 0; wr_b = 0; strb_b = 0; addr_b = 0; wd_b = 0;
        req_c = 0; wr_c = 0; strb_c = 0; addr_c = 0; wd_c = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_aok_a", {31'b0, aok_a}, 32'd0);
        check_eq("rst_aok_c", {31'b0, aok_c}, 32'd0);
        check_eq("rst_dok_a", {31'b0, dok_a}, 32'd0);
        check_eq("rst_dok_b", {31'b0, dok_b}, 32'd0);
        check_eq("rst_rdata_a", rd_a, 32'h0);
        rst_b = 1'b1;

        // 1: first read after reset (word 0 preloaded by a write)
        xact_a("t1_wr0", 1'b1, 32'h0, 32'h0000_0013, 4'hF, 32'h0);
        xact_a("t1_rd0", 1'b0, 32'h0, 32'h0, 4'h0, 32'h0000_0013);

        // 2: strobed write followed immediately by a read of the same word
        xact_a("t2_clr", 1'b1, 32'h100, 32'h0, 4'hF, 32'h0);
        req_a = 1'b1; wr_a = 1'b1; addr_a = 32'h100; wd_a = 32'hDEAD_BEEF; strb_a = 4'b0101;
        @(negedge clk);
        check_eq("t2_wr_dok", {31'b0, dok_a}, 32'd1);
        check_eq("t2_wr_rdata", rd_a, 32'h0);
        wr_a = 1'b0; strb_a = 4'h0;
        @(negedge clk);
        req_a = 1'b0;
        check_eq("t2_rd_dok", {31'b0, dok_a}, 32'd1);
        check_eq("t2_rd_rdata", rd_a, 32'h00AD_00EF);
        @(negedge clk);
        check_eq("t2_idle_dok", {31'b0, dok_a}, 32'd0);
        check_eq("t2_idle_rdata", rd_a, 32'h0);
        xact_a("t2_nostrb", 1'b1, 32'h100, 32'hFFFF_FFFF, 4'h0, 32'h0);
        xact_a("t2_keep", 1'b0, 32'h100, 32'h0, 4'h0, 32'h00AD_00EF);

        // 6: index aliasing and ignored low bits
        xact_a("t6_wrap", 1'b0, 32'h1000, 32'h0, 4'h0, 32'h0000_0013);
        xact_a("t6_lowbits", 1'b0, 32'h103, 32'h0, 4'h0, 32'h00AD_00EF);
        xact_a("t6_high", 1'b0, 32'hFFFF_F100, 32'h0, 4'h0, 32'h00AD_00EF);

        // 3: back-to-back traffic with LATENCY=3
        burst_b("t3_wr", 1'b1);
        burst_b("t3_rd", 1'b0);

        // 4: stall pattern against the reference LFSR
        acc = 0; dok = 0; stalls = 0; mism = 0; rd_bad = 0;
        req_c = 1'b1; wr_c = 1'b1; strb_c = 4'h0; addr_c = 32'h0;
        for (int i = 0; i <= 200; i++) begin
            if (dok_c) begin
                dok++;
                if (rd_c !== 32'h0) rd_bad++;
            end
            if (aok_c !== !(m_lfsr[0] & m_lfsr[1])) mism++;
            if (i < 200) begin
                if (aok_c) acc++;
                else       stalls++;
            end else begin
                req_c = 1'b0;
            end
            @(negedge clk);
        end
        check_eq("t4_acc_eq_dok", 32'(acc), 32'(dok));
        check_eq("t4_aok_model", 32'(mism), 32'd0);
        check_eq("t4_stall_range", {31'b0, (stalls >= 25) && (stalls <= 75)}, 32'd1);
        check_eq("t4_rdata_zero", 32'(rd_bad), 32'd0);

        // 5: reset with two reads in flight
        req_b = 1'b1; wr_b = 1'b0; addr_b = 32'h0;
        @(negedge clk);
        addr_b = 32'h4;
        @(negedge clk);
        req_b = 1'b0;
        rst_b = 1'b0;
        #1;
        check_eq("t5_dok_in_rst", {31'b0, dok_b}, 32'd0);
        check_eq("t5_aok_in_rst", {31'b0, aok_b}, 32'd0);
        @(negedge clk);
        check_eq("t5_dok_rst1", {31'b0, dok_b}, 32'd0);
        @(negedge clk);
        rst_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("t5_dok_post%0d", i), {31'b0, dok_b}, 32'd0);
            @(negedge clk);
        end
        req_b = 1'b1; wr_b = 1'b0; addr_b = 32'h1C;
        @(negedge clk);
        req_b = 1'b0;
        check_eq("t5_keep_lat1", {31'b0, dok_b}, 32'd0);
        @(negedge clk);
        check_eq("t5_keep_lat2", {31'b0, dok_b}, 32'd0);
        @(negedge clk);
        check_eq("t5_keep_dok", {31'b0, dok_b}, 32'd1);
        check_eq("t5_keep_rdata", rd_b, 32'h1000_0007);
        @(negedge clk);
        xact_a("t5_keep_a", 1'b0, 32'h100, 32'h0, 4'h0, 32'h00AD_00EF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
